alu_operand_sequencer: RTL and testbench

Multi-cycle operand staging and writeback stage that sits directly upstream and downstream of the datapath ALU. It holds the 8×16 register file, loads operand registers A and B, and applies a 1-bit shift to B. It drives the ALU's Ain/Bin/ALUop inputs, captures the ALU result and Z flag, and writes the result back to the register file. Commands arrive over a valid/ready handshake and complete with a one-cycle done indication.

---
 rtl/alu_operand_sequencer_if.sv | 51 +++++
 rtl/alu_operand_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Command, preload, ALU and debug signals of alu_operand_sequencer.
// Optional STATUS_NV_EN adds the status_n / status_v outputs.
interface alu_operand_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_rn;
  logic [2:0]  cmd_rm;
  logic [2:0]  cmd_rd;
  logic [1:0]  cmd_shift;
  logic [1:0]  cmd_aluop;
  logic        cmd_wb;
  logic        wr_en;
  logic [2:0]  wr_num;
  logic [15:0] wr_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_z;
  logic [15:0] result;
  logic        status_z;
  logic        done;
  logic [2:0]  dbg_num;
  logic [15:0] dbg_data;
`ifdef STATUS_NV_EN
  logic        status_n;
  logic        status_v;
`endif

  // Command source, preloader and ALU side
  modport master (
    output cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop, cmd_wb,
           wr_en, wr_num, wr_data, alu_out, alu_z, dbg_num,
    input
`ifdef STATUS_NV_EN
           status_n, status_v,
`endif
           cmd_ready, alu_a, alu_b, alu_op, result, status_z, done, dbg_data
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_rn, cmd_rm, cmd_rd, cmd_shift, cmd_aluop, cmd_wb,
           wr_en, wr_num, wr_data, alu_out, alu_z, dbg_num,
    output
`ifdef STATUS_NV_EN
           status_n, status_v,
`endif
           cmd_ready, alu_a, alu_b, alu_op, result, status_z, done, dbg_data
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand staging / writeback stage around the datapath ALU: 8x16 register
// file, A/B operand registers with a 1-bit shift on B, result/Z capture and
// writeback. Optional macro STATUS_NV_EN adds captured N and V flags.
module alu_operand_sequencer (
  input logic                    clk,
  input logic                    reset,
  alu_operand_sequencer_if.slave bus
);
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADA,
    S_LOADB,
    S_EXEC,
    S_WRITE
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [2:0]          rn_q;
  logic [2:0]          rm_q;
  logic [2:0]          rd_q;
  logic [1:0]          shift_q;
  logic                wb_q;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   c_q;
  logic                z_q;
  logic                done_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rm_val;
  logic [DATA_W-1:0]   b_d;

  // Shifted B operand taken from R[rm]
  always_comb begin
    rm_val = regs_q[rm_q];
    b_d    = rm_val;
    case (shift_q)
      2'b01:   b_d = {rm_val[DATA_W-2:0], 1'b0};
      2'b10:   b_d = {1'b0, rm_val[DATA_W-1:1]};
      2'b11:   b_d = {rm_val[DATA_W-1], rm_val[DATA_W-1:1]};
      default: b_d = rm_val;
    endcase
  end

  // Command sequencer, operand/result registers and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      regs_q  <= '{default: '0};
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      shift_q <= '0;
      wb_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // preload and handshake may share an edge; the reads come later
          if (bus.wr_en) regs_q[bus.wr_num] <= bus.wr_data;
          if (bus.cmd_valid) begin
            rn_q    <= bus.cmd_rn;
            rm_q    <= bus.cmd_rm;
            rd_q    <= bus.cmd_rd;
            shift_q <= bus.cmd_shift;
            wb_q    <= bus.cmd_wb;
            op_q    <= bus.cmd_aluop;
            ready_q <= 1'b0;
            state_q <= S_LOADA;
          end
        end
        S_LOADA: begin
          a_q     <= regs_q[rn_q];
          state_q <= S_LOADB;
        end
        S_LOADB: begin
          b_q     <= b_d;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          c_q     <= bus.alu_out;
          z_q     <= bus.alu_z;
          done_q  <= 1'b1;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (wb_q) regs_q[rd_q] <= c_q;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef STATUS_NV_EN
  logic n_q;
  logic v_q;
  logic v_d;

  // Signed overflow of the current ALU operation
  always_comb begin
    v_d = 1'b0;
    case (op_q)
      2'b00:   v_d = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                     (bus.alu_out[DATA_W-1] != a_q[DATA_W-1]);
      2'b01:   v_d = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                     (bus.alu_out[DATA_W-1] != a_q[DATA_W-1]);
      default: v_d = 1'b0;
    endcase
  end

  // N/V capture alongside C and Z
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      n_q <= bus.alu_out[DATA_W-1];
      v_q <= v_d;
    end
  end

  assign bus.status_n = n_q;
  assign bus.status_v = v_q;
`endif

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.result    = c_q;
  assign bus.status_z  = z_q;
  assign bus.dbg_data  = regs_q[bus.dbg_num];

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Testbench for alu_operand_sequencer: behavioural ALU plus a register-file
// reference model; directed spec scenarios followed by randomized commands.
module tb_alu_operand_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [15:0] mdl [8];
  logic [15:0] alu_r;

  alu_operand_sequencer_if bus();

  alu_operand_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the sequencer
  always_comb begin
    case (bus.alu_op)
      2'b00:   alu_r = bus.alu_a + bus.alu_b;
      2'b01:   alu_r = bus.alu_a - bus.alu_b;
      2'b10:   alu_r = bus.alu_a & bus.alu_b;
      default: alu_r = ~bus.alu_b;
    endcase
    bus.alu_out = alu_r;
    bus.alu_z   = (alu_r == 16'd0);
  end

  // Reference for one command from operand values, using signed arithmetic
  function automatic void model_cmd(input logic [15:0] a, input logic [15:0] rmv,
                                    input logic [1:0] sh, input logic [1:0] op,
                                    output logic [15:0] b, output logic [15:0] res,
                                    output logic z, output logic n, output logic v);
    int sa, sb, sr;
    case (sh)
      2'd1:    b = 16'(int'(rmv) * 2);
      2'd2:    b = rmv / 16'd2;
      2'd3:    b = (rmv / 16'd2) + (rmv[15] ? 16'h8000 : 16'h0000);
      default: b = rmv;
    endcase
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    case (op)
      2'd0: begin sr = sa + sb; res = 16'(sr); v = (sr > 32767) || (sr < -32768); end
      2'd1: begin sr = sa - sb; res = 16'(sr); v = (sr > 32767) || (sr < -32768); end
      2'd2: res = a & b;
      default: res = ~b;
    endcase
    z = (res == 16'd0);
    n = res[15];
  endfunction

  task automatic preload(input logic [2:0] num, input logic [15:0] data);
    bus.wr_en = 1'b1; bus.wr_num = num; bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    mdl[num] = data;
  endtask

  // Issue one command (optional preload on the handshake edge); lat = edges
  // from handshake to done, -1 if done never came. Returns once back in IDLE.
  task automatic run_cmd(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                         input logic [1:0] sh, input logic [1:0] op, input logic wb,
                         input logic pl_en, input logic [2:0] pl_num,
                         input logic [15:0] pl_data, output int lat);
    bus.cmd_rn = rn; bus.cmd_rm = rm; bus.cmd_rd = rd;
    bus.cmd_shift = sh; bus.cmd_aluop = op; bus.cmd_wb = wb;
    bus.wr_en = pl_en; bus.wr_num = pl_num; bus.wr_data = pl_data;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.wr_en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    if (lat >= 0) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.wr_en = 1'b0; bus.dbg_num = 3'd0;
    bus.cmd_rn = '0; bus.cmd_rm = '0; bus.cmd_rd = '0;
    bus.cmd_shift = '0; bus.cmd_aluop = '0; bus.cmd_wb = 1'b0;
    bus.wr_num = '0; bus.wr_data = '0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'd0;
    tests_run++;
    if ({bus.cmd_ready, bus.done, bus.status_z} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/done/z=%b expected 100", {bus.cmd_ready, bus.done, bus.status_z});
    end
    tests_run++;
    if ({bus.alu_a, bus.alu_b, bus.result, bus.alu_op} !== 50'd0) begin
      tests_failed++;
      $display("FAIL reset_data: a=%h b=%h c=%h op=%b expected all zero",
               bus.alu_a, bus.alu_b, bus.result, bus.alu_op);
    end
    tests_run++;
    if (bus.dbg_data !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_dbg: got %h expected 0000", bus.dbg_data);
    end
  endtask

  task automatic test_add();
    int lat;
    preload(3'd1, 16'd5);
    preload(3'd2, 16'd7);
    run_cmd(3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 1'b1, 1'b0, 3'd0, 16'd0, lat);
    tests_run++;
    if (lat !== 3) begin tests_failed++; $display("FAIL add_latency: got %0d expected 3", lat); end
    tests_run++;
    if (bus.result !== 16'd12 || bus.status_z !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_result: got %h z=%b expected 000c z=0", bus.result, bus.status_z);
    end
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL add_done_pulse: done=%b expected 0", bus.done); end
    mdl[3] = 16'd12;
    bus.dbg_num = 3'd3; #1;
    tests_run++;
    if (bus.dbg_data !== 16'd12) begin
      tests_failed++; $display("FAIL add_writeback: R3=%h expected 000c", bus.dbg_data);
    end
  endtask

  task automatic test_sub_flags();
    int lat;
    preload(3'd4, 16'd45);
    preload(3'd5, 16'd45);
    run_cmd(3'd4, 3'd5, 3'd6, 2'd0, 2'd1, 1'b0, 1'b0, 3'd0, 16'd0, lat);
    tests_run++;
    if (bus.result !== 16'd0 || bus.status_z !== 1'b1 || lat !== 3) begin
      tests_failed++;
      $display("FAIL sub_zero: got %h z=%b lat=%0d expected 0000 z=1 lat=3", bus.result, bus.status_z, lat);
    end
    bus.dbg_num = 3'd6; #1;
    tests_run++;
    if (bus.dbg_data !== 16'd0) begin
      tests_failed++; $display("FAIL sub_no_wb: R6=%h expected 0000", bus.dbg_data);
    end
  endtask

  task automatic test_shift_not();
    int lat;
    preload(3'd2, 16'h8004);
    run_cmd(3'd0, 3'd2, 3'd7, 2'd3, 2'd3, 1'b1, 1'b0, 3'd0, 16'd0, lat);
    mdl[7] = 16'h3FFD;
    tests_run++;
    if (bus.alu_b !== 16'hC002 || bus.result !== 16'h3FFD) begin
      tests_failed++;
      $display("FAIL asr_not: b=%h c=%h expected c002 3ffd", bus.alu_b, bus.result);
    end
    bus.dbg_num = 3'd7; #1;
    tests_run++;
    if (bus.dbg_data !== 16'h3FFD) begin
      tests_failed++; $display("FAIL asr_not_wb: R7=%h expected 3ffd", bus.dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    int hs[$];
    int low_cnt;
    int lat;
    logic [15:0] b, r;
    logic z, n, v;
    low_cnt = 0;
    preload(3'd0, 16'h0055);
    preload(3'd1, 16'h0003);
    preload(3'd2, 16'h0010);
    bus.cmd_rn = 3'd1; bus.cmd_rm = 3'd2; bus.cmd_rd = 3'd1;
    bus.cmd_shift = 2'd0; bus.cmd_aluop = 2'd0; bus.cmd_wb = 1'b1;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 20 && hs.size() < 2; k++) begin
      if (bus.cmd_ready === 1'b1) hs.push_back(k);
      else if (hs.size() == 1) low_cnt++;
      if (hs.size() == 1 && k == hs[0] + 2) begin
        bus.wr_en = 1'b1; bus.wr_num = 3'd0; bus.wr_data = 16'hDEAD;
      end else begin
        bus.wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0; bus.wr_en = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      if (bus.done === 1'b1) begin lat = i; break; end
      @(posedge clk); #1;
    end
    if (lat >= 0) begin @(posedge clk); #1; end
    for (int c = 0; c < 2; c++) begin
      model_cmd(mdl[1], mdl[2], 2'd0, 2'd0, b, r, z, n, v);
      mdl[1] = r;
    end
    tests_run++;
    if (hs.size() != 2 || lat < 0) begin
      tests_failed++; $display("FAIL b2b_handshakes: got %0d handshakes, done_seen=%0d expected 2,1", hs.size(), lat >= 0);
    end else begin
      tests_run++;
      if (hs[1] - hs[0] != 5 || low_cnt != 4) begin
        tests_failed++;
        $display("FAIL b2b_spacing: gap=%0d ready_low=%0d expected 5 and 4", hs[1] - hs[0], low_cnt);
      end
    end
    bus.dbg_num = 3'd0; #1;
    tests_run++;
    if (bus.dbg_data !== mdl[0]) begin
      tests_failed++; $display("FAIL b2b_preload_ignored: R0=%h expected %h", bus.dbg_data, mdl[0]);
    end
    bus.dbg_num = 3'd1; #1;
    tests_run++;
    if (bus.dbg_data !== mdl[1]) begin
      tests_failed++; $display("FAIL b2b_chain: R1=%h expected %h", bus.dbg_data, mdl[1]);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    preload(3'd1, 16'h1111);
    preload(3'd2, 16'h2222);
    bus.cmd_rn = 3'd1; bus.cmd_rm = 3'd2; bus.cmd_rd = 3'd5;
    bus.cmd_shift = 2'd0; bus.cmd_aluop = 2'd0; bus.cmd_wb = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    for (int i = 0; i < 8; i++) mdl[i] = 16'd0;
    tests_run++;
    if ({bus.cmd_ready, bus.done, bus.status_z} !== 3'b100 ||
        {bus.alu_a, bus.alu_b, bus.result, bus.alu_op} !== 50'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: ready=%b done=%b a=%h b=%h c=%h expected 1 0 0000 0000 0000",
               bus.cmd_ready, bus.done, bus.alu_a, bus.alu_b, bus.result);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    bus.dbg_num = 3'd5; #1;
    tests_run++;
    if (done_cnt != 0 || bus.dbg_data !== 16'd0) begin
      tests_failed++; $display("FAIL reset_mid_no_write: done_pulses=%0d R5=%h expected 0 0000", done_cnt, bus.dbg_data);
    end
  endtask

`ifdef STATUS_NV_EN
  task automatic test_nv();
    int lat;
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run_cmd(3'd1, 3'd2, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0, 3'd0, 16'd0, lat);
    tests_run++;
    if (bus.result !== 16'h8000 || {bus.status_n, bus.status_v, bus.status_z} !== 3'b110) begin
      tests_failed++;
      $display("FAIL nv_overflow: c=%h nvz=%b expected 8000 110", bus.result,
               {bus.status_n, bus.status_v, bus.status_z});
    end
  endtask
`endif

  task automatic test_random();
    int lat;
    logic [2:0] rn, rm, rd, pn;
    logic [1:0] sh, op;
    logic wb, pe;
    logic [15:0] pd, a, b, r;
    logic z, n, v;
    logic [15:0] corner [4];
    corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000; corner[3] = 16'hFFFF;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        preload(3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom));
      rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7)); rd = 3'($urandom_range(0, 7));
      sh = 2'($urandom_range(0, 3)); op = 2'($urandom_range(0, 3)); wb = 1'($urandom_range(0, 1));
      pe = 1'($urandom_range(0, 1)); pn = 3'($urandom_range(0, 7));
      pd = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      if (pe) mdl[pn] = pd;
      a = mdl[rn];
      model_cmd(a, mdl[rm], sh, op, b, r, z, n, v);
      run_cmd(rn, rm, rd, sh, op, wb, pe, pn, pd, lat);
      if (wb) mdl[rd] = r;
      tests_run++;
      if (lat !== 3 || bus.alu_a !== a || bus.alu_b !== b || bus.alu_op !== op) begin
        tests_failed++;
        $display("FAIL rand_operands[%0d]: lat=%0d a=%h b=%h op=%b expected 3 %h %h %b",
                 t, lat, bus.alu_a, bus.alu_b, bus.alu_op, a, b, op);
      end
      tests_run++;
      if (bus.result !== r || bus.status_z !== z) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: c=%h z=%b expected %h %b", t, bus.result, bus.status_z, r, z);
      end
`ifdef STATUS_NV_EN
      tests_run++;
      if (bus.status_n !== n || bus.status_v !== v) begin
        tests_failed++;
        $display("FAIL rand_nv[%0d]: n=%b v=%b expected %b %b", t, bus.status_n, bus.status_v, n, v);
      end
`endif
      bus.dbg_num = rd; #1;
      tests_run++;
      if (bus.dbg_data !== mdl[rd]) begin
        tests_failed++; $display("FAIL rand_regfile[%0d]: R%0d=%h expected %h", t, rd, bus.dbg_data, mdl[rd]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_flags();
    test_shift_not();
    test_back_to_back();
    test_reset_mid();
`ifdef STATUS_NV_EN
    test_nv();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
